// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl
// Purpose : In-order pipeline control: E..W scoreboard, load-use stall,
//           decode flush on redirect, operand forwarding, retire counter.
// Rev     : 1.0
// ============================================================================
module pipe_ctrl #(
    parameter  int XLEN       = 32,
    parameter  int STAGES     = 3,
    parameter  int LOAD_STAGE = 2,
    localparam int FWD_W      = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic              issue_lsu,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        rs1_addr_D,
    input  logic [4:0]        rs2_addr_D,
    input  logic              rs1_used_D,
    input  logic              rs2_used_D,
    input  logic              mem_stall,
    input  logic              redirect_E,
    output logic              stall_D,
    output logic              flush_D,
    output logic [FWD_W-1:0]  fwd1_E,
    output logic [FWD_W-1:0]  fwd2_E,
    output logic [STAGES-1:0] stage_valid,
    output logic [XLEN-1:0]   retire_count
);

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_wr;
    logic [STAGES-1:0] r_lsu;
    logic [4:0]        r_rd [STAGES];
    // Source operands only matter while the instruction sits in E.
    logic [4:0]        r_e_rs1;
    logic [4:0]        r_e_rs2;
    logic              r_e_rs1_used;
    logic              r_e_rs2_used;
    logic [XLEN-1:0]   r_retire;

    logic              w_hazard;
    logic              w_advance;
    logic              w_new_valid;

    // A producer in stage j reaches its ready stage in time only if j+1 >= ready stage.
    always_comb begin
        w_hazard = 1'b0;
        for (int j = 0; j < STAGES; j++) begin
            if (r_valid[j] && r_wr[j] && (r_rd[j] != 5'd0) &&
                ((j + 1) < (r_lsu[j] ? LOAD_STAGE : 1)) &&
                ((rs1_used_D && (r_rd[j] == rs1_addr_D)) ||
                 (rs2_used_D && (r_rd[j] == rs2_addr_D)))) begin
                w_hazard = 1'b1;
            end
        end
    end

    function automatic logic [FWD_W-1:0] fwd_sel(input logic [4:0] rs, input logic used);
        logic [FWD_W-1:0] sel;
        sel = '0;
        // Descending scan so the youngest (lowest-index) match wins.
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (r_valid[k] && r_wr[k] && (r_rd[k] == rs) &&
                (!r_lsu[k] || (k >= LOAD_STAGE))) begin
                sel = FWD_W'(k);
            end
        end
        if (!r_valid[0] || !used || (rs == 5'd0)) begin
            sel = '0;
        end
        return sel;
    endfunction

    assign w_advance   = !mem_stall;
    assign w_new_valid = issue_valid && !w_hazard && !redirect_E;

    assign stall_D      = reset_n && (mem_stall || (w_hazard && issue_valid && !redirect_E));
    assign flush_D      = reset_n && redirect_E && !mem_stall;
    assign fwd1_E       = fwd_sel(r_e_rs1, r_e_rs1_used);
    assign fwd2_E       = fwd_sel(r_e_rs2, r_e_rs2_used);
    assign stage_valid  = r_valid;
    assign retire_count = r_retire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= '0;
            r_wr         <= '0;
            r_lsu        <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_rd[k] <= 5'd0;
            end
            r_e_rs1      <= 5'd0;
            r_e_rs2      <= 5'd0;
            r_e_rs1_used <= 1'b0;
            r_e_rs2_used <= 1'b0;
            r_retire     <= '0;
        end else if (w_advance) begin
            r_valid      <= {r_valid[STAGES-2:0], w_new_valid};
            r_wr         <= {r_wr[STAGES-2:0], issue_wr};
            r_lsu        <= {r_lsu[STAGES-2:0], issue_lsu};
            r_rd[0]      <= issue_rd;
            for (int k = 1; k < STAGES; k++) begin
                r_rd[k] <= r_rd[k-1];
            end
            r_e_rs1      <= rs1_addr_D;
            r_e_rs2      <= rs2_addr_D;
            r_e_rs1_used <= rs1_used_D;
            r_e_rs2_used <= rs2_used_D;
            if (r_valid[STAGES-1]) begin
                r_retire <= r_retire + XLEN'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the in-order integer core. It replaces the ad-hoc stall wiring between decode, execute, memory and writeback. It tracks every in-flight instruction from execute (E) through writeback in a STAGES-deep scoreboard and generates load-use stall, decode flush on redirect, and per-operand forwarding selects. A retired-instruction counter is included.

Parameters:
XLEN, 32, width of retire counter
STAGES, 3, tracked stages after decode (index 0 = E, 1 = M, ..., STAGES-1 = W); legal range 2..8
LOAD_STAGE, 2, stage index at which load data first becomes forwardable; legal range 1..STAGES-1
FWD_W, $clog2(STAGES), forward-select width (derived; not overridden)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
issue_valid  in  1  decode holds a valid instruction
issue_wr  in  1  decode instruction writes rd
issue_lsu  in  1  decode instruction is a load
issue_rd  in  5  decode rd address
rs1_addr_D  in  5  decode rs1 address
rs2_addr_D  in  5  decode rs2 address
rs1_used_D  in  1  decode instruction reads rs1
rs2_used_D  in  1  decode instruction reads rs2
mem_stall  in  1  memory stage stall (freezes entire pipe)
redirect_E  in  1  jump/branch taken in E this cycle
stall_D  out  1  hold fetch/decode
flush_D  out  1  kill decode instruction
fwd1_E  out  FWD_W  rs1 forward source for E instruction: 0 = register file, k = stage k
fwd2_E  out  FWD_W  rs2 forward source, same encoding
stage_valid  out  STAGES  valid bit per tracked stage
retire_count  out  XLEN  instructions retired from stage STAGES-1

Behaviour:
- Entry per stage: {valid, wr, lsu, rd, rs1, rs2, rs1_used, rs2_used}. Reset (async): all valid=0, retire_count=0. While reset_n=0: stall_D=0, flush_D=0, fwd*=0.
- Advance when mem_stall=0: entry[k] <= entry[k-1] for k>=1; entry[0] <= decode fields with valid = issue_valid & !hazard & !redirect_E, else bubble (valid=0).
- mem_stall=1: all entries hold; stall_D=1; flush_D=0; redirect_E ignored. redirect_E must be held by E until the pipe advances.
- Hazard (decode vs entry j, j = 0..STAGES-1): entry valid & wr & rd!=0 & rd matches a used rs. Ready stage R = LOAD_STAGE if lsu, else 1. Hazard when j+1 < R. stall_D = mem_stall | (hazard & issue_valid & !redirect_E).
- Redirect priority: flush_D = redirect_E & !mem_stall. The decode instruction is killed, a bubble is inserted into E, and any hazard is ignored that cycle. The E instruction (the jump itself) advances normally.
- Forwarding (combinational, for entry[0]): for each used rs with rs!=0, pick the youngest k in 1..STAGES-1 with entry[k] valid & wr & rd==rs.
  - A non-load in stage >=1 is forwardable.
  - A load is forwardable only if k >= LOAD_STAGE.
  - The hazard logic guarantees no unforwardable match reaches E.
  - No match, or entry[0] invalid, gives 0.
- Retire: retire_count += 1 (wraps modulo 2^XLEN) on each advance where entry[STAGES-1].valid=1.
- The register file writes at the end of stage STAGES-1. An instruction in decode reading an rd written by an entry that has left the tracked stages reads the register file.

Test Plan:
- Reset with reset_n=0 mid-stream (3 valid entries) -> stage_valid=0, retire_count=0 immediately (async); stall_D=0.
- ALU back-to-back: addi x5 then add x6,x5,x5, defaults -> no stall; next cycle fwd1_E=1, fwd2_E=1; one cycle later both 0 when producer retires past W and the consumer has moved on.
- Load-use: lw x7 then add x8,x7,x0 (STAGES=3, LOAD_STAGE=2) -> stall_D=1 for exactly 1 cycle, bubble in E; consumer in E gets fwd1_E=2, fwd2_E=0 (x0).
- Redirect with simultaneous load-use hazard -> flush_D=1, stall_D=0, stage_valid[0]=0 next cycle, jump entry advances to stage 1.
- mem_stall held 4 cycles with 3 valid entries -> stage_valid and retire_count frozen; stall_D=1 throughout; redirect_E asserted during the stall is not acted on until release.
- STAGES=5, LOAD_STAGE=3: load followed by consumer -> stall_D for 2 cycles, then fwd1_E=3; 100 instructions with no hazards -> retire_count=100.
